// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter: GPR write-back arbiter merging the ALU path with a buffered mul/div/load FIFO.
// Optional WB_TRACE_EN prints a line per committed write.  Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic [31:0] alu_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        regwrite,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [31:0] pc_new,
  output logic [31:0] busy_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [4:0]       r_mem_reg  [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [31:0]      r_mem_pc   [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [STV_W-1:0] r_starve;
  logic             r_force;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_take_alu;
  logic        w_commit;
  logic [4:0]  w_sel_reg;
  logic [31:0] w_sel_data;
  logic [31:0] w_sel_pc;
  logic [31:0] w_busy;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign md_ready  = !w_full;
  assign alu_ready = !r_force;

  // $0 results complete the handshake but never occupy a slot.
  assign w_push     = md_valid && !w_full && (md_reg != 5'd0);
  assign w_take_alu = alu_valid && !r_force;
  assign w_pop      = !w_empty && (r_force || !alu_valid);
  assign w_commit   = w_pop || w_take_alu;

  assign w_sel_reg  = w_pop ? r_mem_reg[r_rd_ptr]  : alu_reg;
  assign w_sel_data = w_pop ? r_mem_data[r_rd_ptr] : alu_data;
  assign w_sel_pc   = w_pop ? r_mem_pc[r_rd_ptr]   : alu_pc;

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count) begin
        w_busy[r_mem_reg[r_rd_ptr + PTR_W'(i)]] = 1'b1;
      end
    end
    w_busy[0] = 1'b0;
  end

  assign busy_mask = w_busy;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wr_ptr]  <= md_reg;
      r_mem_data[r_wr_ptr] <= md_data;
      r_mem_pc[r_wr_ptr]   <= md_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_force    <= 1'b0;
      regwrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      pc_new     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

      // Force is raised on the same edge the counter reaches STARVE_MAX.
      if (w_pop || w_empty) begin
        r_starve <= '0;
        r_force  <= 1'b0;
      end else if (w_take_alu) begin
        r_starve <= r_starve + STV_W'(1);
        if (r_starve >= STV_W'(STARVE_MAX - 1)) r_force <= 1'b1;
      end

      if (w_commit && (w_sel_reg != 5'd0)) begin
        regwrite   <= 1'b1;
        write_reg  <= w_sel_reg;
        write_data <= w_sel_data;
        pc_new     <= w_sel_pc;
      end else begin
        regwrite   <= 1'b0;
      end
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_commit && (w_sel_reg != 5'd0)) begin
      $display("@%h: $%0d <= %h", w_sel_pc, w_sel_reg, w_sel_data);
    end
  end
`else
`endif

endmodule

`default_nettype wire
